tbec_rsc_encoder_wr: RTL and testbench

Write-path stage that feeds the TBEC RSC decoder's memory. It accepts 16-bit data words with an address, computes the 16 TBEC RSC redundancy bits, and writes the 32-bit codeword to memory through a request/grant port. It has a 2-deep pipeline with full backpressure. A one-shot error-injection facility lets the bench corrupt exactly one stored codeword, so that the decoder's correction and flag paths can be exercised.

---
 rtl/tbec_rsc_encoder_wr.sv | 187 ++++++++++++++++++
 tb/tb_tbec_rsc_encoder_wr.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tbec_rsc_encoder_wr.sv
// TBEC RSC write-path encoder: two-stage pipeline that turns 16-bit data words into
// 32-bit codewords, with a one-shot error-injection mask applied to a single word.
module tbec_rsc_encoder_wr #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:15]       in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              inj_arm,
  input  logic [0:31]       inj_mask,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [0:31]       mem_wdata,
  output logic              inj_done,
  output logic [15:0]       wr_count
);

  typedef enum logic [0:0] {
    INJ_IDLE  = 1'b0,
    INJ_ARMED = 1'b1
  } inj_state_e;

  function automatic logic [0:15] tbec_redundancy(input logic [0:15] d);
    logic [0:15] r;
    r[0]  = d[0]  ^ d[2]  ^ d[5]  ^ d[7];
    r[1]  = d[9]  ^ d[11] ^ d[12] ^ d[14];
    r[2]  = d[1]  ^ d[3]  ^ d[4]  ^ d[6];
    r[3]  = d[8]  ^ d[10] ^ d[13] ^ d[15];
    r[4]  = d[0]  ^ d[1]  ^ d[4]  ^ d[5];
    r[5]  = d[10] ^ d[11] ^ d[14] ^ d[15];
    r[6]  = d[2]  ^ d[3]  ^ d[6]  ^ d[7];
    r[7]  = d[8]  ^ d[9]  ^ d[12] ^ d[13];
    r[8]  = d[0]  ^ d[8];
    r[9]  = d[4]  ^ d[12];
    r[10] = d[1]  ^ d[9];
    r[11] = d[5]  ^ d[13];
    r[12] = d[2]  ^ d[10];
    r[13] = d[6]  ^ d[14];
    r[14] = d[3]  ^ d[11];
    r[15] = d[7]  ^ d[15];
    return r;
  endfunction

  inj_state_e        inj_state_r, inj_state_s;
  logic [0:31]       inj_mask_r;
  logic              tag_s;

  logic              s1_valid_r;
  logic [0:15]       s1_data_r;
  logic [ADDR_W-1:0] s1_addr_r;
  logic              s1_tag_r;

  logic              s2_valid_r;
  logic [0:31]       s2_cw_r;
  logic [ADDR_W-1:0] s2_addr_r;
  logic              s2_tag_r;

  logic              inj_done_r;
  logic [15:0]       wr_count_r;

  logic              s2_free_s;
  logic              s1_move_s;
  logic              accept_s;
  logic [0:31]       s1_cw_s;

  // Pipeline handshake: S2 drains on grant, S1 advances into a free S2.
  always_comb begin
    s2_free_s = s2_valid_r & mem_gnt;
    s1_move_s = s1_valid_r & (~s2_valid_r | s2_free_s);
    in_ready  = rst_n & (~s1_valid_r | s1_move_s);
    accept_s  = in_valid & in_ready;
    if (s1_tag_r) begin
      s1_cw_s = {s1_data_r, tbec_redundancy(s1_data_r)} ^ inj_mask_r;
    end else begin
      s1_cw_s = {s1_data_r, tbec_redundancy(s1_data_r)};
    end
  end

  // Injection FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_state_r <= INJ_IDLE;
    end else begin
      inj_state_r <= inj_state_s;
    end
  end

  // Injection FSM next state; a re-arm while armed is ignored.
  always_comb begin
    inj_state_s = inj_state_r;
    case (inj_state_r)
      INJ_IDLE: begin
        if (inj_arm) begin
          inj_state_s = INJ_ARMED;
        end else begin
          inj_state_s = INJ_IDLE;
        end
      end
      INJ_ARMED: begin
        if (accept_s) begin
          inj_state_s = INJ_IDLE;
        end else begin
          inj_state_s = INJ_ARMED;
        end
      end
      default: inj_state_s = INJ_IDLE;
    endcase
  end

  // Injection FSM output: tag the word accepted while armed.
  always_comb begin
    tag_s = 1'b0;
    case (inj_state_r)
      INJ_IDLE:  tag_s = 1'b0;
      INJ_ARMED: tag_s = accept_s;
      default:   tag_s = 1'b0;
    endcase
  end

  // Mask is captured only when arming from idle, so the first mask wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_mask_r <= 32'h0000_0000;
    end else if ((inj_state_r == INJ_IDLE) && inj_arm) begin
      inj_mask_r <= inj_mask;
    end
  end

  // Stage S1: input register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= 16'h0000;
      s1_addr_r  <= {ADDR_W{1'b0}};
      s1_tag_r   <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_data_r  <= in_data;
      s1_addr_r  <= in_addr;
      s1_tag_r   <= tag_s;
    end else if (s1_move_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Stage S2: codeword register, held stable until granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_cw_r    <= 32'h0000_0000;
      s2_addr_r  <= {ADDR_W{1'b0}};
      s2_tag_r   <= 1'b0;
    end else if (s1_move_s) begin
      s2_valid_r <= 1'b1;
      s2_cw_r    <= s1_cw_s;
      s2_addr_r  <= s1_addr_r;
      s2_tag_r   <= s1_tag_r;
    end else if (s2_free_s) begin
      s2_valid_r <= 1'b0;
      s2_tag_r   <= 1'b0;
    end
  end

  // Grant bookkeeping: injection-done pulse and saturating write counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_done_r <= 1'b0;
      wr_count_r <= 16'h0000;
    end else begin
      inj_done_r <= s2_free_s & s2_tag_r;
      if (s2_free_s && (wr_count_r != 16'hFFFF)) begin
        wr_count_r <= wr_count_r + 16'd1;
      end
    end
  end

  assign mem_req   = s2_valid_r;
  assign mem_addr  = s2_addr_r;
  assign mem_wdata = s2_cw_r;
  assign inj_done  = inj_done_r;
  assign wr_count  = wr_count_r;

endmodule

// File: tb/tb_tbec_rsc_encoder_wr.sv
// Directed testbench for tbec_rsc_encoder_wr: encoding, backpressure, streaming,
// injection, reset mid-flight and a bench-side single-error decode loopback.
module tb_tbec_rsc_encoder_wr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [0:15] in_data;
  logic [7:0]  in_addr;
  logic        inj_arm;
  logic [0:31] inj_mask;
  logic        mem_req;
  logic        mem_gnt;
  logic [7:0]  mem_addr;
  logic [0:31] mem_wdata;
  logic        inj_done;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int inj_done_cnt = 0;
  logic [0:31] wr_data_q[$];
  logic [7:0]  wr_addr_q[$];
  int          wr_cyc_q[$];

  tbec_rsc_encoder_wr #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_addr(in_addr), .inj_arm(inj_arm), .inj_mask(inj_mask),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .inj_done(inj_done), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: a write is granted on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && mem_req && mem_gnt) begin
      wr_data_q.push_back(mem_wdata);
      wr_addr_q.push_back(mem_addr);
      wr_cyc_q.push_back(cyc);
    end
    if (rst_n && inj_done) inj_done_cnt++;
  end

  function automatic logic [0:15] ref_red(input logic [0:15] d);
    logic [0:15] r;
    r[0]  = d[0]^d[2]^d[5]^d[7];
    r[1]  = d[9]^d[11]^d[12]^d[14];
    r[2]  = d[1]^d[3]^d[4]^d[6];
    r[3]  = d[8]^d[10]^d[13]^d[15];
    r[4]  = d[0]^d[1]^d[4]^d[5];
    r[5]  = d[10]^d[11]^d[14]^d[15];
    r[6]  = d[2]^d[3]^d[6]^d[7];
    r[7]  = d[8]^d[9]^d[12]^d[13];
    r[8]  = d[0]^d[8];   r[9]  = d[4]^d[12];
    r[10] = d[1]^d[9];   r[11] = d[5]^d[13];
    r[12] = d[2]^d[10];  r[13] = d[6]^d[14];
    r[14] = d[3]^d[11];  r[15] = d[7]^d[15];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 16'h0000;
    in_addr  = 8'h00;
    inj_arm  = 1'b0;
    inj_mask = 32'h0000_0000;
    mem_gnt  = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    wr_data_q.delete();
    wr_addr_q.delete();
    wr_cyc_q.delete();
    inj_done_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    inj_arm  = 1'b0;
    mem_gnt  = 1'b1;
    in_data  = 16'h0000;
    in_addr  = 8'h00;
    inj_mask = 32'h0000_0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr got %h want 00", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    checks++; if (inj_done !== 1'b0) begin errors++; $display("FAIL reset_inj_done got %b want 0", inj_done); end
    checks++; if (wr_count !== 16'h0) begin errors++; $display("FAIL reset_wr_count got %h want 0", wr_count); end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    logic [0:15] dv[4];
    logic [0:31] cv[4];
    dv[0] = 16'h0000; cv[0] = 32'h0000_0000;
    dv[1] = 16'hFFFF; cv[1] = 32'hFFFF_0000;
    dv[2] = 16'h8000; cv[2] = 32'h8000_8880;
    dv[3] = 16'h0001; cv[3] = 32'h0001_1401;
    do_reset();
    mem_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = dv[i];
      in_addr  = 8'h40 + 8'(i);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL single_req_early[%0d] got %b want 0", i, mem_req); end
      tick();
      @(negedge clk);
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL single_req[%0d] got %b want 1", i, mem_req); end
      checks++; if (mem_addr !== 8'h40 + 8'(i)) begin errors++; $display("FAIL single_addr[%0d] got %h want %h", i, mem_addr, 8'h40 + 8'(i)); end
      checks++; if (mem_wdata !== cv[i]) begin errors++; $display("FAIL single_wdata[%0d] got %h want %h", i, mem_wdata, cv[i]); end
      tick();
    end
    @(negedge clk);
    checks++; if (wr_count !== 16'd4) begin errors++; $display("FAIL single_wr_count got %0d want 4", wr_count); end
  endtask

  task automatic test_backpressure();
    logic [0:31] cv[3];
    cv[0] = 32'h1234_411C;
    cv[1] = 32'h5678_F05C;
    cv[2] = 32'h9ABC_B11C;
    do_reset();
    mem_gnt  = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h1234; in_addr = 8'h01;
    tick();
    in_data  = 16'h5678; in_addr = 8'h02;
    tick();
    in_data  = 16'h9ABC; in_addr = 8'h03;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
      checks++; if (mem_req !== 1'b1 || mem_wdata !== cv[0] || mem_addr !== 8'h01) begin
        errors++; $display("FAIL bp_hold[%0d] got req=%b addr=%h data=%h want req=1 addr=01 data=%h", i, mem_req, mem_addr, mem_wdata, cv[0]);
      end
      tick();
    end
    checks++; if (wr_data_q.size() != 0) begin errors++; $display("FAIL bp_no_write got %0d writes want 0", wr_data_q.size()); end
    mem_gnt = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (wr_data_q.size() != 3) begin
      errors++; $display("FAIL bp_count got %0d writes want 3", wr_data_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (wr_data_q[i] !== cv[i] || wr_addr_q[i] !== 8'(i + 1)) begin
          errors++; $display("FAIL bp_order[%0d] got addr=%h data=%h want addr=%h data=%h", i, wr_addr_q[i], wr_data_q[i], 8'(i + 1), cv[i]);
        end
      end
      checks++; if (wr_cyc_q[2] - wr_cyc_q[0] != 2) begin errors++; $display("FAIL bp_consecutive got span %0d want 2", wr_cyc_q[2] - wr_cyc_q[0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [0:15] d;
    do_reset();
    mem_gnt  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 16'(i * 16'h1357 + 16'h00A5);
      in_addr = 8'(i);
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b want 1", i, in_ready); end
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (wr_data_q.size() != 16) begin
      errors++; $display("FAIL stream_count got %0d writes want 16", wr_data_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        d = 16'(i * 16'h1357 + 16'h00A5);
        checks++; if (wr_data_q[i] !== {d, ref_red(d)} || wr_addr_q[i] !== 8'(i)) begin
          errors++; $display("FAIL stream_word[%0d] got addr=%h data=%h want addr=%h data=%h", i, wr_addr_q[i], wr_data_q[i], 8'(i), {d, ref_red(d)});
        end
      end
      checks++; if (wr_cyc_q[15] - wr_cyc_q[0] != 15) begin errors++; $display("FAIL stream_bubbles got span %0d want 15", wr_cyc_q[15] - wr_cyc_q[0]); end
    end
    checks++; if (wr_count !== 16'd16) begin errors++; $display("FAIL stream_wr_count got %0d want 16", wr_count); end
  endtask

  task automatic test_injection();
    do_reset();
    mem_gnt  = 1'b1;
    inj_arm  = 1'b1;
    inj_mask = 32'h8000_0000;
    tick();
    inj_mask = 32'h0000_0001;
    tick();
    inj_arm  = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h0000; in_addr = 8'h10;
    tick();
    in_addr  = 8'h11;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    // Arm coinciding with an acceptance tags the following word instead.
    inj_arm  = 1'b1;
    inj_mask = 32'h0001_0000;
    in_valid = 1'b1;
    in_addr  = 8'h20;
    tick();
    inj_arm  = 1'b0;
    in_addr  = 8'h21;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (wr_data_q.size() != 4) begin
      errors++; $display("FAIL inj_count got %0d writes want 4", wr_data_q.size());
    end else begin
      checks++; if (wr_data_q[0] !== 32'h8000_0000) begin errors++; $display("FAIL inj_first_mask got %h want 80000000", wr_data_q[0]); end
      checks++; if (wr_data_q[1] !== 32'h0000_0000) begin errors++; $display("FAIL inj_next_clean got %h want 00000000", wr_data_q[1]); end
      checks++; if (wr_data_q[2] !== 32'h0000_0000) begin errors++; $display("FAIL inj_same_cycle_untagged got %h want 00000000", wr_data_q[2]); end
      checks++; if (wr_data_q[3] !== 32'h0001_0000) begin errors++; $display("FAIL inj_following_tagged got %h want 00010000", wr_data_q[3]); end
    end
    checks++; if (inj_done_cnt != 2) begin errors++; $display("FAIL inj_done_pulses got %0d want 2", inj_done_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_gnt  = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'hAAAA; in_addr = 8'h30;
    tick();
    in_data  = 16'h5555; in_addr = 8'h31;
    tick();
    in_valid = 1'b0;
    inj_arm  = 1'b1;
    inj_mask = 32'h0000_0001;
    tick();
    inj_arm  = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_full got req=%b ready=%b want 1 0", mem_req, in_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mid_req_drop got %b want 0", mem_req); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_low got %b want 0", in_ready); end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL mid_empty got ready=%b req=%b want 1 0", in_ready, mem_req); end
    checks++; if (wr_count !== 16'h0) begin errors++; $display("FAIL mid_wr_count got %0d want 0", wr_count); end
    checks++; if (wr_data_q.size() != 0) begin errors++; $display("FAIL mid_no_write got %0d writes want 0", wr_data_q.size()); end
    mem_gnt  = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0000; in_addr = 8'h05;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (wr_data_q.size() != 1 || wr_data_q[0] !== 32'h0) begin
      errors++; $display("FAIL mid_inj_cancelled got n=%0d data=%h want n=1 data=00000000", wr_data_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 32'h0);
    end
    checks++; if (inj_done_cnt != 0) begin errors++; $display("FAIL mid_inj_done got %0d want 0", inj_done_cnt); end
  endtask

  task automatic test_loopback();
    logic [0:15] d, dr, syn, fixed, oh;
    logic [0:31] m, cw;
    int bitpos;
    do_reset();
    mem_gnt = 1'b1;
    for (int t = 0; t < 6; t++) begin
      d      = 16'($urandom);
      bitpos = $urandom_range(0, 15);
      m      = (t < 4) ? (32'h8000_0000 >> bitpos) : 32'h0000_0000;
      inj_arm  = 1'b1;
      inj_mask = m;
      tick();
      inj_arm  = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_addr  = 8'(t);
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      cw = (wr_data_q.size() > 0) ? wr_data_q[$] : 32'h0;
      dr  = cw[0:15];
      syn = ref_red(dr) ^ cw[16:31];
      fixed = dr;
      for (int i = 0; i < 16; i++) begin
        oh = 16'h8000 >> i;
        if (syn != 16'h0 && ref_red(oh) == syn) fixed = dr ^ oh;
      end
      checks++; if (fixed !== d) begin errors++; $display("FAIL loop_data[%0d] got %h want %h", t, fixed, d); end
      checks++; if ((syn != 16'h0) !== (m != 32'h0)) begin errors++; $display("FAIL loop_flag[%0d] got syn=%h want nonzero=%b", t, syn, (m != 32'h0)); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_injection();
    test_reset_mid();
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
